// File: rtl/cim_bitserial_macro.sv
// Bit-serial compute-in-memory macro: ROWS x COLS bit-cell array, one input bit-plane per cycle.
// Define CIM_SIGNED_EN for two's-complement inputs (MSB plane subtracted, signed DOut).
module cim_bitserial_macro #(
    parameter int unsigned ROWS    = 128,
    parameter int unsigned COLS    = 64,
    parameter int unsigned IN_BITS = 4,
    localparam int unsigned AW     = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int unsigned CW     = (COLS > 1) ? $clog2(COLS) : 1,
`ifdef CIM_SIGNED_EN
    localparam int unsigned SIGN_W = 1,
`else
    localparam int unsigned SIGN_W = 0,
`endif
    localparam int unsigned ACC_W  = $clog2(ROWS + 1) + IN_BITS + SIGN_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     we,
    input  logic [AW-1:0]            waddr,
    input  logic [COLS-1:0]          wdata,
    input  logic                     start,
    input  logic [ROWS-1:0]          wl,
    input  logic [ROWS*IN_BITS-1:0]  in_b,
    output logic                     busy,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CW-1:0]            out_col,
    output logic [ACC_W-1:0]         dout
);

    localparam int unsigned PW = $clog2(ROWS + 1);
    localparam int unsigned NW = $clog2(IN_BITS + 1);

    typedef enum logic [1:0] {StIdle, StCompute, StDrain} state_e;

    state_e                  state_q, state_d;
    logic [COLS-1:0]         cell_q [ROWS];
    logic [ROWS-1:0]         wl_q;
    logic [ROWS*IN_BITS-1:0] in_b_q;
    logic [NW-1:0]           plane_q;
    logic [ROWS-1:0]         act;
    logic [PW-1:0]           pop_d [COLS];
    logic [PW-1:0]           pop_q [COLS];
    logic                    pop_vld_q;
    logic [NW-1:0]           pop_plane_q;
    logic [ACC_W-1:0]        acc_d [COLS];
    logic [ACC_W-1:0]        acc_q [COLS];
    logic [ACC_W-1:0]        term;
    logic [CW-1:0]           col_q;
    logic                    planes_done;
    logic                    last_col;

    assign planes_done = (plane_q == NW'(IN_BITS));
    assign last_col    = (col_q == CW'(COLS - 1));

    // Cell array has no reset: contents survive Rst.
    always_ff @(posedge clk) begin
        if (we && (state_q == StIdle)) begin
            cell_q[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (start) state_d = StCompute;
            StCompute: if (planes_done) state_d = StDrain;
            StDrain:   if (out_ready && last_col) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // Rows that contribute in the current plane: wordline enabled and input bit set.
    always_comb begin
        for (int r = 0; r < int'(ROWS); r++) begin
            act[r] = 1'b0;
            for (int p = 0; p < int'(IN_BITS); p++) begin
                if (plane_q == NW'(p)) begin
                    act[r] = wl_q[r] & in_b_q[r*IN_BITS + p];
                end
            end
        end
    end

    always_comb begin
        for (int c = 0; c < int'(COLS); c++) begin
            pop_d[c] = '0;
            for (int r = 0; r < int'(ROWS); r++) begin
                pop_d[c] = pop_d[c] + PW'(cell_q[r][c] & act[r]);
            end
        end
    end

    // Popcounts are registered, then weighted and accumulated one cycle later.
    always_comb begin
        term = '0;
        for (int c = 0; c < int'(COLS); c++) begin
            term = ACC_W'(pop_q[c]) << pop_plane_q;
`ifdef CIM_SIGNED_EN
            if (pop_plane_q == NW'(IN_BITS - 1)) begin
                acc_d[c] = acc_q[c] - term;
            end else begin
                acc_d[c] = acc_q[c] + term;
            end
`else
            acc_d[c] = acc_q[c] + term;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wl_q        <= '0;
            in_b_q      <= '0;
            plane_q     <= '0;
            pop_vld_q   <= 1'b0;
            pop_plane_q <= '0;
            col_q       <= '0;
            for (int c = 0; c < int'(COLS); c++) begin
                pop_q[c] <= '0;
                acc_q[c] <= '0;
            end
        end else begin
            pop_vld_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        wl_q    <= wl;
                        in_b_q  <= in_b;
                        plane_q <= '0;
                        col_q   <= '0;
                        for (int c = 0; c < int'(COLS); c++) begin
                            acc_q[c] <= '0;
                        end
                    end
                end
                StCompute: begin
                    if (!planes_done) begin
                        pop_vld_q   <= 1'b1;
                        pop_plane_q <= plane_q;
                        plane_q     <= plane_q + NW'(1);
                        for (int c = 0; c < int'(COLS); c++) begin
                            pop_q[c] <= pop_d[c];
                        end
                    end
                    if (pop_vld_q) begin
                        for (int c = 0; c < int'(COLS); c++) begin
                            acc_q[c] <= acc_d[c];
                        end
                    end
                end
                StDrain: begin
                    if (out_ready) begin
                        col_q <= last_col ? '0 : col_q + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        busy      = (state_q != StIdle);
        out_valid = (state_q == StDrain);
        out_col   = '0;
        dout      = '0;
        if (state_q == StDrain) begin
            out_col = col_q;
            dout    = acc_q[col_q];
        end
    end

endmodule

// File: doc/cim_bitserial_macro.md
CIM_BITSERIAL_MACRO -- requirements
Module: cim_bitserial_macro

Interface
REQ-001 Parameter ROWS, default 128: wordline count, which is also the number of input elements per operation.
REQ-002 Parameter COLS, default 64: bitline (output column) count.
REQ-003 Parameter IN_BITS, default 4: bit-width of each input element, processed one bit-plane per cycle.
REQ-004 Derived ACC_W = clog2(ROWS+1)+IN_BITS, plus 1 when CIM_SIGNED_EN is defined.
REQ-005 Clk  in  1  single clock; all state updates on its rising edge.
REQ-006 Rst  in  1  reset, asynchronous, active-low.
REQ-007 WE  in  1  row-write enable.
REQ-008 WAddr  in  clog2(ROWS)  row written when WE=1.
REQ-009 WData  in  COLS  row data; bit c is stored in column c.
REQ-010 Start  in  1  operation request, accepted only in IDLE.
REQ-011 WL  in  ROWS  wordline enable mask, latched at Start.
REQ-012 In_B  in  ROWS*IN_BITS  input vector latched at Start; element r = In_B[r*IN_BITS +: IN_BITS].
REQ-013 Busy  out  1  high in COMPUTE and DRAIN.
REQ-014 Out_Valid  out  1  result beat valid.
REQ-015 Out_Ready  in  1  consumer accepts the beat.
REQ-016 Out_Col  out  clog2(COLS)  column index of the current beat.
REQ-017 DOut  out  ACC_W  column result.

Function
REQ-018 The FSM SHALL have three states: IDLE, COMPUTE and DRAIN.
REQ-019 IDLE->COMPUTE on Start; WL and In_B are latched, the accumulators are cleared and the plane counter is set to 0.
REQ-020 In COMPUTE, on each cycle with plane p = 0..IN_BITS-1 (LSB first), for every column c: acc[c] += popcount over r of (cell[r][c] & WL[r] & bit p of element r), shifted left by p.
REQ-021 After plane IN_BITS-1 the FSM SHALL enter DRAIN. Out_Valid is first asserted IN_BITS+1 cycles after the Start edge.
REQ-022 In DRAIN, Out_Valid=1, Out_Col starts at 0 and DOut=acc[Out_Col]; Out_Col advances only when Out_Valid&Out_Ready.
REQ-023 While Out_Ready=0, Out_Col and DOut SHALL hold stable.
REQ-024 On acceptance of column COLS-1, the FSM SHALL return to IDLE; Out_Valid and Busy go low on the next cycle.
REQ-025 Start while Busy=1 SHALL be ignored: no queuing and no change to latched inputs.
REQ-026 Writes SHALL occur only in IDLE; WE while Busy=1 is ignored.
REQ-027 WE and Start in the same IDLE cycle: the write completes at that edge, so COMPUTE sees the new row.
REQ-028 Accumulator arithmetic SHALL be ACC_W wide and never overflow at the maximum (ROWS*(2^IN_BITS-1)).
REQ-029 Outside DRAIN, DOut=0 and Out_Col=0.

Reset
REQ-030 Rst=0 SHALL asynchronously force IDLE, Busy=0, Out_Valid=0, Out_Col=0, DOut=0, and clear the accumulators and plane counter.
REQ-031 The cell array SHALL NOT be reset; its contents persist through reset.
REQ-032 Reset asserted mid-COMPUTE or mid-DRAIN SHALL abort the operation; no partial beats are emitted after release.
REQ-033 The first Start after reset release SHALL behave identically to a Start after power-up.

Configuration
REQ-034 Macro CIM_SIGNED_EN defined: input elements are two's complement, the plane IN_BITS-1 contribution is subtracted, and DOut is a signed two's-complement value.
REQ-035 Macro CIM_SIGNED_EN undefined: inputs are unsigned, all planes are added, and DOut is unsigned.

Verification (ROWS=128, COLS=64, IN_BITS=4, Out_Ready=1 unless stated)
REQ-036 All rows written all-ones, WL all-ones, every element 4'hF, Start -> Out_Valid rises 5 cycles later; 64 beats, Out_Col 0..63, each DOut=1920 (unsigned build).
REQ-037 Array all-zero, then row 0 = only bit 3 set, WL[0]=1, element 0 = 9, Start -> column 3 DOut=9, all other columns 0.
REQ-038 Array all-ones, WL=0, any In_B -> all 64 beats DOut=0; with WL bits 0..9 set and elements=1 -> all DOut=10.
REQ-039 Out_Ready held low for 10 cycles at Out_Col=5 -> Out_Col=5 and DOut stable throughout; a Start pulse during that window -> ignored, and drain continues to 63, then IDLE.
REQ-040 Rst=0 asserted at Out_Col=20 -> outputs zero immediately, Busy=0; a re-Start after release -> full correct 64 beats using the retained array contents.
REQ-041 CIM_SIGNED_EN build, row 0 all-ones, WL[0]=1, element 0 = 4'b1111 -> every DOut = -1 (all ones, ACC_W bits); unsigned build with the same stimulus -> every DOut = 15.
